// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add/subtract that pushes one nibble per cycle
// through a single 4-bit lookahead slice. The ripple carry is held in a register
// between steps, and the result is returned over a valid/ready handshake.

// 4-bit carry-lookahead slice: sum, carry out, and group propagate/generate.
module simp_alu74181 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       pout,
  output logic       gout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  // Lookahead carries are formed from the per-bit generate/propagate terms.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    gout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    pout = &p;
    cout = gout | (pout & cin);
    s    = p ^ c;
  end

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KLAST = KW'(N - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;

  logic [3:0] slice_a;
  logic [3:0] slice_b;
  logic [3:0] slice_s;
  logic       slice_cout;
  logic       slice_pout_unused;
  logic       slice_gout_unused;

  // The current nibble of each latched operand feeds the slice.
  assign slice_a = a_q[{k_q, 2'b00} +: 4];
  assign slice_b = b_q[{k_q, 2'b00} +: 4];

  simp_alu74181 u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout),
    .pout (slice_pout_unused),
    .gout (slice_gout_unused)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: accept in IDLE, step N nibbles in RUN, hold in DONE until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)      state_d = RUN;
      RUN:     if (k_q == KLAST)  state_d = DONE;
      DONE:    if (out_ready)     state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Operand latch on accept; one nibble of sum and the ripple carry per RUN cycle.
  // The counter holds at the terminal count instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b ^ {WIDTH{op_sub}};
            carry_q <= op_sub;
            k_q     <= '0;
          end
        end
        RUN: begin
          sum_q[{k_q, 2'b00} +: 4] <= slice_s;
          carry_q                  <= slice_cout;
          if (k_q != KLAST) k_q <= k_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs come from registers only; reset additionally forces in_ready low.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = carry_q;
  assign ovf       = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_q[WIDTH-1] != a_q[WIDTH-1]);
  assign zero      = ~|sum_q;

endmodule
